// File: rtl/coarse_gain_agc_if.sv
// Purpose: bundles the AGC control, monitored sample and gain outputs between the controller and its user.
// Latency: none, wires only.
// Backpressure: none; data_i is one sample per cycle, the outputs are free-running registers.
// Ports: enable/config/data in toward the controller; log2_gain_o, gain_update_o, state_o out of it.
interface coarse_gain_agc_if #(
    parameter int DATA_WIDTH      = 14,
    parameter int WIDTH_LOG2_GAIN = 2,
    parameter int WINDOW_WIDTH    = 16
);
    logic                          enable_i;
    logic [WIDTH_LOG2_GAIN-1:0]    init_log2_gain_i;
    logic [WINDOW_WIDTH-1:0]       window_len_i;
    logic [7:0]                    clip_limit_i;
    logic [3:0]                    quiet_windows_i;
    logic signed [DATA_WIDTH-1:0]  data_i;
    logic [WIDTH_LOG2_GAIN-1:0]    log2_gain_o;
    logic                          gain_update_o;
    logic [1:0]                    state_o;

    // slave: the controller itself
    modport slave (
        input  enable_i, init_log2_gain_i, window_len_i, clip_limit_i, quiet_windows_i, data_i,
        output log2_gain_o, gain_update_o, state_o
    );

    // master: whoever configures the controller and feeds it samples
    modport master (
        output enable_i, init_log2_gain_i, window_len_i, clip_limit_i, quiet_windows_i, data_i,
        input  log2_gain_o, gain_update_o, state_o
    );
endinterface

// File: rtl/coarse_gain_agc.sv
// Purpose: AGC for the coarse power-of-two gain stage; counts clips/loud samples per window and steps the gain.
// Latency: gain decision registered one cycle after the last window sample; SETTLE_CYCLES blanking after each change.
// Backpressure: none; one sample consumed every MEASURE cycle, enable_i low aborts to IDLE on the next edge.
// Ports: clk_i, rst_i (async active-high), agc (slave modport: enable/config/data in, gain/pulse/state out).
module coarse_gain_agc #(
    parameter int DATA_WIDTH      = 14,
    parameter int MAX_LOG2_GAIN   = 3,
    parameter int WIDTH_LOG2_GAIN = 2,
    parameter int WINDOW_WIDTH    = 16,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    coarse_gain_agc_if.slave agc
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SETTLE  = 2'd2
    } state_e;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WIDTH_LOG2_GAIN-1:0] MAX_G = WIDTH_LOG2_GAIN'(MAX_LOG2_GAIN);
    localparam logic [SW-1:0]              SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic signed [DATA_WIDTH-1:0] CLIP_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] CLIP_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] LOUD_POS = DATA_WIDTH'(2 ** (DATA_WIDTH - 3));
    localparam logic signed [DATA_WIDTH-1:0] LOUD_NEG = -LOUD_POS;

    state_e                      state_q, state_d;
    logic [WIDTH_LOG2_GAIN-1:0]  gain_q, gain_d;
    logic                        upd_q, upd_d;
    logic [WINDOW_WIDTH-1:0]     sample_cnt_q, sample_cnt_d;
    logic [WINDOW_WIDTH-1:0]     win_len_q, win_len_d;
    logic [7:0]                  clip_lim_q, clip_lim_d;
    logic [3:0]                  quiet_lim_q, quiet_lim_d;
    logic [7:0]                  clip_cnt_q, clip_cnt_d;
    logic                        loud_q, loud_d;
    logic [3:0]                  quiet_cnt_q, quiet_cnt_d;
    logic [SW-1:0]               settle_cnt_q, settle_cnt_d;

    logic                        is_clip, is_loud, win_start, win_end, clip_trig;
    logic [WINDOW_WIDTH-1:0]     win_len_eff, cnt_now;
    logic [7:0]                  clip_lim_eff, clip_now;
    logic [3:0]                  quiet_lim_eff, quiet_inc;
    logic                        loud_now;
    logic [WIDTH_LOG2_GAIN-1:0]  init_clamped;

    assign is_clip = (agc.data_i == CLIP_POS) || (agc.data_i == CLIP_NEG);
    assign is_loud = (agc.data_i >= LOUD_POS) || (agc.data_i <= LOUD_NEG);

    // Settings are taken live on the first sample of a window (so a
    // 1-sample window can decide immediately) and held from the latch after.
    assign win_start     = (sample_cnt_q == '0);
    assign win_len_eff   = !win_start ? win_len_q :
                           (agc.window_len_i == '0) ? WINDOW_WIDTH'(1) : agc.window_len_i;
    assign clip_lim_eff  = !win_start ? clip_lim_q :
                           (agc.clip_limit_i == '0) ? 8'd1 : agc.clip_limit_i;
    assign quiet_lim_eff = !win_start ? quiet_lim_q :
                           (agc.quiet_windows_i == '0) ? 4'd1 : agc.quiet_windows_i;

    // Counts including the current sample, used for the window-end decision.
    assign cnt_now   = sample_cnt_q + WINDOW_WIDTH'(1);
    assign clip_now  = (clip_cnt_q == 8'hFF) ? 8'hFF : clip_cnt_q + {7'd0, is_clip};
    assign loud_now  = loud_q | is_loud;
    assign win_end   = (cnt_now == win_len_eff);
    assign clip_trig = (clip_now >= clip_lim_eff);
    assign quiet_inc = (quiet_cnt_q == 4'hF) ? 4'hF : quiet_cnt_q + 4'd1;

    assign init_clamped = (agc.init_log2_gain_i > MAX_G) ? MAX_G : agc.init_log2_gain_i;

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        upd_d        = 1'b0;
        sample_cnt_d = sample_cnt_q;
        win_len_d    = win_len_q;
        clip_lim_d   = clip_lim_q;
        quiet_lim_d  = quiet_lim_q;
        clip_cnt_d   = clip_cnt_q;
        loud_d       = loud_q;
        quiet_cnt_d  = quiet_cnt_q;
        settle_cnt_d = settle_cnt_q;

        if (state_q == ST_IDLE || !agc.enable_i) begin
            // Disable wins over any same-cycle decision; IDLE tracks init gain.
            if (state_q == ST_IDLE) begin
                gain_d = init_clamped;
            end
            state_d      = agc.enable_i ? ST_MEASURE : ST_IDLE;
            sample_cnt_d = '0;
            clip_cnt_d   = '0;
            loud_d       = 1'b0;
            quiet_cnt_d  = '0;
            settle_cnt_d = '0;
        end else if (state_q == ST_MEASURE) begin
            win_len_d   = win_len_eff;
            clip_lim_d  = clip_lim_eff;
            quiet_lim_d = quiet_lim_eff;
            if (!win_end) begin
                sample_cnt_d = cnt_now;
                clip_cnt_d   = clip_now;
                loud_d       = loud_now;
            end else begin
                sample_cnt_d = '0;
                clip_cnt_d   = '0;
                loud_d       = 1'b0;
                if (clip_trig) begin
                    quiet_cnt_d = '0;
                    if (gain_q != '0) begin
                        gain_d       = gain_q - WIDTH_LOG2_GAIN'(1);
                        upd_d        = 1'b1;
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end
                end else if (!loud_now) begin
                    if (quiet_inc >= quiet_lim_eff) begin
                        if (gain_q < MAX_G) begin
                            gain_d       = gain_q + WIDTH_LOG2_GAIN'(1);
                            upd_d        = 1'b1;
                            quiet_cnt_d  = '0;
                            state_d      = ST_SETTLE;
                            settle_cnt_d = '0;
                        end else begin
                            quiet_cnt_d = quiet_lim_eff;
                        end
                    end else begin
                        quiet_cnt_d = quiet_inc;
                    end
                end else begin
                    quiet_cnt_d = '0;
                end
            end
        end else begin
            // SETTLE: blank the gain pipeline, window counters already cleared.
            if (settle_cnt_q == SETTLE_LAST) begin
                state_d      = ST_MEASURE;
                settle_cnt_d = '0;
            end else begin
                settle_cnt_d = settle_cnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            gain_q       <= '0;
            upd_q        <= 1'b0;
            sample_cnt_q <= '0;
            win_len_q    <= '0;
            clip_lim_q   <= '0;
            quiet_lim_q  <= '0;
            clip_cnt_q   <= '0;
            loud_q       <= 1'b0;
            quiet_cnt_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            upd_q        <= upd_d;
            sample_cnt_q <= sample_cnt_d;
            win_len_q    <= win_len_d;
            clip_lim_q   <= clip_lim_d;
            quiet_lim_q  <= quiet_lim_d;
            clip_cnt_q   <= clip_cnt_d;
            loud_q       <= loud_d;
            quiet_cnt_q  <= quiet_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign agc.log2_gain_o   = gain_q;
    assign agc.gain_update_o = upd_q;
    assign agc.state_o       = state_q;
endmodule

// File: tb/tb_coarse_gain_agc.sv
// Purpose: directed self-checking bench for coarse_gain_agc.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Backpressure: n/a; every wait is a fixed number of clock cycles.
module tb_coarse_gain_agc;
    logic clk_i = 1'b0;
    logic rst_i;
    int   tests = 0;
    int   fails = 0;
    int   pulses;

    always #5 clk_i = ~clk_i;

    coarse_gain_agc_if agc_bus ();

    coarse_gain_agc dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .agc   (agc_bus)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int g, input int u, input int s);
        chk({tag, ".gain"},  32'(agc_bus.log2_gain_o),   32'(g));
        chk({tag, ".upd"},   32'(agc_bus.gain_update_o), 32'(u));
        chk({tag, ".state"}, 32'(agc_bus.state_o),       32'(s));
    endtask

    initial begin
        rst_i                    = 1'b1;
        agc_bus.enable_i         = 1'b0;
        agc_bus.init_log2_gain_i = 2'd2;
        agc_bus.window_len_i     = 16'd8;
        agc_bus.clip_limit_i     = 8'd2;
        agc_bus.quiet_windows_i  = 4'd15;
        agc_bus.data_i           = '0;

        // Reset and idle
        tick(2);
        chk_out("reset", 0, 0, 0);
        rst_i = 1'b0;
        tick(1);
        chk_out("idle_load", 2, 0, 0);

        // Clip step-down: 3 clips of 8191 in an 8-sample window, limit 2
        agc_bus.enable_i = 1'b1;
        tick(1);
        chk_out("enable", 2, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            agc_bus.data_i = (i <= 3) ? 14'sd8191 : 14'sd0;
            tick(1);
            if (i == 7) chk_out("clip_pre_end", 2, 0, 1);
        end
        chk_out("clip_end", 1, 1, 2);
        agc_bus.data_i = '0;
        tick(1);
        chk_out("settle1", 1, 0, 2);
        tick(2);
        chk_out("settle3", 1, 0, 2);
        tick(1);
        chk_out("settle_exit", 1, 0, 1);

        // Quiet step-up: init 1, window 10, 3 quiet windows
        agc_bus.enable_i         = 1'b0;
        agc_bus.init_log2_gain_i = 2'd1;
        tick(2);
        chk_out("idle_init1", 1, 0, 0);
        agc_bus.window_len_i    = 16'd10;
        agc_bus.quiet_windows_i = 4'd3;
        agc_bus.data_i          = 14'sd100;
        agc_bus.enable_i        = 1'b1;
        tick(1);
        tick(29);
        chk_out("quiet_pre", 1, 0, 1);
        tick(1);
        chk_out("quiet_up2", 2, 1, 2);
        tick(33);
        chk_out("quiet_pre3", 2, 0, 1);
        tick(1);
        chk_out("quiet_up3", 3, 1, 2);
        pulses = 0;
        for (int i = 0; i < 46; i++) begin
            tick(1);
            if (agc_bus.gain_update_o) pulses++;
        end
        chk("quiet_hold_pulses", 32'(pulses), 32'd0);
        chk_out("quiet_hold", 3, 0, 1);

        // Floor: gain 0, constant -8192 clipping
        agc_bus.enable_i         = 1'b0;
        agc_bus.init_log2_gain_i = 2'd0;
        tick(2);
        chk_out("idle_init0", 0, 0, 0);
        agc_bus.window_len_i = 16'd8;
        agc_bus.clip_limit_i = 8'd2;
        agc_bus.data_i       = -14'sd8192;
        agc_bus.enable_i     = 1'b1;
        tick(1);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (agc_bus.gain_update_o) pulses++;
        end
        chk("floor_pulses", 32'(pulses), 32'd0);
        chk_out("floor", 0, 0, 1);

        // Loud reset: quiet, quiet, loud(2048), quiet, quiet -> no step; 6th quiet -> step
        pulses = 0;
        for (int i = 1; i <= 48; i++) begin
            agc_bus.data_i = (i == 20) ? 14'sd2048 : 14'sd0;
            tick(1);
            if (i <= 40 && agc_bus.gain_update_o) pulses++;
            if (i == 40) begin
                chk("loud_pulses", 32'(pulses), 32'd0);
                chk("loud_gain", 32'(agc_bus.log2_gain_o), 32'd0);
            end
        end
        chk_out("loud_then_quiet", 1, 1, 2);

        // Abort: drop enable on the window-end cycle of a clipping window
        agc_bus.enable_i         = 1'b0;
        agc_bus.init_log2_gain_i = 2'd3;
        tick(2);
        chk_out("idle_init3", 3, 0, 0);
        agc_bus.clip_limit_i = 8'd1;
        agc_bus.data_i       = 14'sd8191;
        agc_bus.enable_i     = 1'b1;
        tick(1);
        tick(7);
        agc_bus.enable_i = 1'b0;
        tick(1);
        chk_out("abort", 3, 0, 0);

        // Mid-window window_len change 8 -> 4 does not shorten current window
        agc_bus.data_i   = '0;
        agc_bus.enable_i = 1'b1;
        tick(1);
        for (int i = 1; i <= 8; i++) begin
            agc_bus.data_i = (i == 3) ? 14'sd8191 : 14'sd0;
            if (i == 4) agc_bus.window_len_i = 16'd4;
            tick(1);
            if (i == 4) chk_out("len_change_mid", 3, 0, 1);
        end
        chk_out("len_change_end", 2, 1, 2);

        // Zero substitution: window 0 and clip limit 0 behave as 1
        agc_bus.enable_i = 1'b0;
        tick(2);
        agc_bus.window_len_i = 16'd0;
        agc_bus.clip_limit_i = 8'd0;
        agc_bus.data_i       = '0;
        agc_bus.enable_i     = 1'b1;
        tick(1);
        chk_out("zero_sub_start", 3, 0, 1);
        agc_bus.data_i = 14'sd8191;
        tick(1);
        chk_out("zero_sub", 2, 1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coarse_gain_agc.md
# coarse_gain_agc

Automatic gain controller for the coarse gain and limiter stage of the pt_feedback path. It watches the limited output samples and counts clipped samples over a programmable measurement window. It steps the stage's power-of-two gain down when the output clips and up after a run of quiet windows. Its `log2_gain_o` drives the gain stage's `log2_gain_i`, and its `data_i` taps that stage's `data_o`.

## Interface

**Parameters**
- `DATA_WIDTH`, default 14: width of the signed monitored sample.
- `MAX_LOG2_GAIN`, default 3: highest gain code the controller may issue.
- `WIDTH_LOG2_GAIN`, default 2: width of the gain code.
- `WINDOW_WIDTH`, default 16: width of the window-length setting.
- `SETTLE_CYCLES`, default 4: number of samples ignored after a gain change. This covers the adder and gain pipeline.

**Ports** (clock and reset first)
- `clk_i`, in, 1: system clock. All logic is on the rising edge.
- `rst_i`, in, 1: asynchronous reset, active-high.
- `enable_i`, in, 1: run the AGC. When 0, the controller sits in IDLE.
- `init_log2_gain_i`, in, `WIDTH_LOG2_GAIN`: gain code applied while idle.
- `window_len_i`, in, `WINDOW_WIDTH`: samples per window. A value of 0 is treated as 1.
- `clip_limit_i`, in, 8: clipped samples per window that trigger a gain decrease. A value of 0 is treated as 1.
- `quiet_windows_i`, in, 4: consecutive quiet windows that trigger a gain increase. A value of 0 is treated as 1.
- `data_i`, in, `DATA_WIDTH`: signed two's-complement monitored sample, one per cycle.
- `log2_gain_o`, out, `WIDTH_LOG2_GAIN`: registered gain code.
- `gain_update_o`, out, 1: one-cycle pulse on the cycle `log2_gain_o` changes because of an AGC decision.
- `state_o`, out, 2: current state. IDLE=0, MEASURE=1, SETTLE=2.

## Operation

**Sample classification**
- A sample is *clipped* if `data_i` equals `2^(DATA_WIDTH-1)-1` or `-2^(DATA_WIDTH-1)`.
- A sample is *loud* if `|data_i| >= 2^(DATA_WIDTH-3)`, i.e. quarter full scale. The most negative value counts as loud.

**IDLE**
- Every cycle, `log2_gain_o` loads `min(init_log2_gain_i, MAX_LOG2_GAIN)`.
- All counters are cleared.
- When `enable_i`=1, move to MEASURE.

**MEASURE**
- At window start, latch `window_len_i`, `clip_limit_i` and `quiet_windows_i` after the 0→1 substitution. Later changes to these inputs take effect at the next window.
- Every MEASURE cycle counts one sample.
- The clip counter is 8 bits and saturates at 255.
- A loud flag is set if any sample in the window is loud.

**End of window** (the cycle that counts sample number `window_len`). The decision uses the counts including that last sample and is applied in priority order:
1. If clip count ≥ limit and gain > 0: decrement the gain, clear the quiet counter, go to SETTLE.
2. If clip count ≥ limit and gain = 0: no change, clear the quiet counter, start a new window.
3. Otherwise, if the loud flag is clear: increment the quiet counter (saturates at 15).
   - If it reaches the limit and gain < `MAX_LOG2_GAIN`: increment the gain, clear the quiet counter, go to SETTLE.
   - At `MAX_LOG2_GAIN`: no change, and the quiet counter holds at the limit.
4. Otherwise (loud window with no clip trigger): clear the quiet counter and start a new window.

**SETTLE**
- Ignore `SETTLE_CYCLES` samples, then return to MEASURE with a fresh window.
- The quiet counter persists across windows but not across a gain change.

**Other rules**
- `enable_i`=0 in any state sends the controller to IDLE on the next edge. This has priority over a same-cycle window-end decision: no update and no pulse.
- If `rst_i` is asserted mid-operation, all state is cleared immediately.

## Timing

- Reset values:
  - `log2_gain_o` = 0
  - `gain_update_o` = 0
  - `state_o` = IDLE
  - all counters = 0
- `enable_i` rising edge sampled at edge k: `state_o`=MEASURE after edge k. The first counted sample is the one presented in the following cycle.
- Decision latency is one cycle. At the edge ending the last window cycle, `log2_gain_o` takes its new value, `gain_update_o`=1 for exactly that one cycle, and `state_o`=SETTLE.
- SETTLE lasts exactly `SETTLE_CYCLES` cycles, then MEASURE.
- The minimum spacing between two gain updates is `window_len` + `SETTLE_CYCLES` cycles.
- `gain_update_o` never asserts in IDLE and never asserts when the code is unchanged.

## Test plan

- **Reset/idle:** assert `rst_i`, then release with `enable_i`=0 and `init_log2_gain_i`=2 → `log2_gain_o`=0 during reset, 2 one cycle after release, `state_o`=0, no pulse.
- **Clip step-down:** init 2, `window_len_i`=8, `clip_limit_i`=2, feed 3 samples of 8191 within the window → at the window end `log2_gain_o`=1 with a single pulse, then 4 SETTLE cycles, then MEASURE.
- **Quiet step-up:** init 1, `window_len_i`=10, `quiet_windows_i`=3, constant `data_i`=100 → after 30 MEASURE cycles `log2_gain_o`=2. Continuing, the next steps to 3 occur every 3 windows plus SETTLE, and the code then holds at 3 with no further pulses.
- **Floor and loud reset:** at gain 0 feed -8192 each cycle → no change and no pulse. A window containing one sample of 2048 with no clips resets the quiet counter: 2 quiet windows, a loud window, then 2 quiet windows with `quiet_windows_i`=3 → no increase.
- **Priority/abort:** drop `enable_i` on the window-end cycle of a clipping window → no pulse, IDLE next cycle, `log2_gain_o` = init. Changing `window_len_i` mid-window from 8 to 4 → the current window still ends at 8 samples.
- **Zero substitution:** `window_len_i`=0 with `clip_limit_i`=0 and one clip at gain 3 → 1-sample window, `log2_gain_o`=2 on the next edge.
